// File: rtl/iter_span_builder.sv
// iter_span_builder: rasterises the outline of one convex polygon into a per-row
// span table by walking each edge with Bresenham. The scanner reads [x0, x1]
// for row y combinationally; rows never touched read as empty (x0 > x1).
// Optional feature macro: ITER_SPAN_BBOX_EN adds bbox_y0/bbox_y1 outputs and
// limits the table clear to the rows touched by the previous build.
module iter_span_builder #(
    parameter int CORDW    = 10,
    parameter int SCREEN_H = 480,
    parameter int MAXV     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      vert_we,
    input  logic [$clog2(MAXV)-1:0]   vert_idx,
    input  logic [CORDW-1:0]          vert_x,
    input  logic [CORDW-1:0]          vert_y,
    input  logic [$clog2(MAXV):0]     nvert,
    input  logic                      start,
    input  logic [CORDW-1:0]          y,
    output logic [CORDW-1:0]          x0,
    output logic [CORDW-1:0]          x1,
    output logic                      busy,
    output logic                      done
`ifdef ITER_SPAN_BBOX_EN
    ,
    output logic [CORDW-1:0]          bbox_y0,
    output logic [CORDW-1:0]          bbox_y1
`endif
);

    localparam int VW = $clog2(MAXV);
    localparam int NW = VW + 1;
    localparam int RW = $clog2(SCREEN_H);
    localparam int SW = CORDW + 2;
    localparam logic [CORDW-1:0] H_LIM    = CORDW'(SCREEN_H);
    localparam logic [RW-1:0]    ROW_LAST = RW'(SCREEN_H - 1);
    localparam logic [CORDW-1:0] ONE      = CORDW'(1);

    typedef enum logic [2:0] {IDLE, CLEAR, EDGE_INIT, EDGE_WALK, FINISH} state_t;

    state_t                state, state_nx;
    logic [CORDW-1:0]      vx [MAXV];
    logic [CORDW-1:0]      vy [MAXV];
    logic [NW-1:0]         nv, ei;
    logic [RW-1:0]         row, row_end, clr_lo, clr_hi;
    logic [CORDW-1:0]      cx, cy, xe, ye, cx_nx, cy_nx;
    logic                  sx_neg, sy_neg, valid;
    logic signed [SW-1:0]  dx, dy, err, err_nx;
    logic signed [SW:0]    e2;
    logic [CORDW-1:0]      tx0 [SCREEN_H];
    logic [CORDW-1:0]      tx1 [SCREEN_H];

    // Edge endpoint selection: v[i] -> v[(i+1) mod nv]
    logic [VW-1:0]         ia, ib;
    logic [CORDW-1:0]      xa, xb, ya, yb, dxu, dyu;
    logic                  at_end, cy_ok;
    logic [RW-1:0]         cy_idx;
    logic [CORDW-1:0]      cur_x0, cur_x1;

    assign ia     = ei[VW-1:0];
    assign ib     = (ei + NW'(1) == nv) ? '0 : VW'(ei + NW'(1));
    assign xa     = vx[ia];
    assign ya     = vy[ia];
    assign xb     = vx[ib];
    assign yb     = vy[ib];
    assign dxu    = (xb >= xa) ? xb - xa : xa - xb;
    assign dyu    = (yb >= ya) ? yb - ya : ya - yb;
    assign at_end = (cx == xe) && (cy == ye);
    assign cy_ok  = cy < H_LIM;
    assign cy_idx = cy[RW-1:0];
    assign cur_x0 = tx0[cy_idx];
    assign cur_x1 = tx1[cy_idx];
    assign e2     = {err, 1'b0};
    assign busy   = (state != IDLE);

    // Bresenham step from the current point and error term
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        err_nx = err;
        cx_nx  = cx;
        cy_nx  = cy;
        if (e2 >= (SW+1)'(dy)) begin
            err_nx = err_nx + dy;
            cx_nx  = sx_neg ? cx - ONE : cx + ONE;
        end
        if (e2 <= (SW+1)'(dx)) begin
            err_nx = err_nx + dx;
            cy_nx  = sy_neg ? cy - ONE : cy + ONE;
        end
    end

    // Row range the next CLEAR pass must cover
    always_comb begin
        clr_lo = '0;
        clr_hi = ROW_LAST;
`ifdef ITER_SPAN_BBOX_EN
        if (valid && (bbox_y0 <= bbox_y1)) begin
            clr_lo = bbox_y0[RW-1:0];
            clr_hi = bbox_y1[RW-1:0];
        end
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state always uses non-blocking assignments.
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (start) state_nx = CLEAR;
            CLEAR:     if (row == row_end) state_nx = (nv == '0) ? FINISH : EDGE_INIT;
            EDGE_INIT: state_nx = EDGE_WALK;
            EDGE_WALK: if (at_end) state_nx = (ei + NW'(1) < nv) ? EDGE_INIT : FINISH;
            FINISH:    state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Control flags that must return to a known value on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done  <= 1'b0;
            valid <= 1'b0;
`ifdef ITER_SPAN_BBOX_EN
            bbox_y0 <= '1;
            bbox_y1 <= '0;
`endif
        end else begin
            done <= (state == FINISH);
            if (state == FINISH) valid <= 1'b1;
`ifdef ITER_SPAN_BBOX_EN
            if (state == IDLE && start) begin
                bbox_y0 <= '1;
                bbox_y1 <= '0;
            end else if (state == EDGE_WALK && cy_ok) begin
                if (cy < bbox_y0) bbox_y0 <= cy;
                if (cy > bbox_y1) bbox_y1 <= cy;
            end
`endif
        end
    end

    // Vertex registers, edge walker datapath and span table
    always_ff @(posedge clk) begin
        // NOTE: vertex registers and the span table are deliberately not reset; valid hides stale rows.
        if (vert_we && state == IDLE) begin
            vx[vert_idx] <= vert_x;
            vy[vert_idx] <= vert_y;
        end
        case (state)
            IDLE: begin
                if (start) begin
                    nv      <= (nvert > NW'(MAXV)) ? NW'(MAXV) : nvert;
                    row     <= clr_lo;
                    row_end <= clr_hi;
                end
            end
            CLEAR: begin
                tx0[row] <= '1;
                tx1[row] <= '0;
                row      <= row + RW'(1);
                if (row == row_end) ei <= '0;
            end
            EDGE_INIT: begin
                cx     <= xa;
                cy     <= ya;
                xe     <= xb;
                ye     <= yb;
                sx_neg <= xb < xa;
                sy_neg <= yb < ya;
                dx     <= SW'(dxu);
                dy     <= -SW'(dyu);
                err    <= SW'(dxu) - SW'(dyu);
            end
            EDGE_WALK: begin
                if (cy_ok) begin
                    tx0[cy_idx] <= (cx < cur_x0) ? cx : cur_x0;
                    tx1[cy_idx] <= (cx > cur_x1) ? cx : cur_x1;
                end
                if (at_end) begin
                    ei <= ei + NW'(1);
                end else begin
                    cx  <= cx_nx;
                    cy  <= cy_nx;
                    err <= err_nx;
                end
            end
            default: ;
        endcase
    end

    // Asynchronous read port, forced empty while building or before the first build
    always_comb begin
        x0 = '1;
        x1 = '0;
        if (!busy && valid && (y < H_LIM)) begin
            x0 = tx0[y[RW-1:0]];
            x1 = tx1[y[RW-1:0]];
        end
    end

endmodule

// File: tb/tb_iter_span_builder.sv
// Self-checking bench for iter_span_builder: table-driven row reads plus
// hand-written build sequences (latency, start while busy, reset mid-walk).
// Define ITER_SPAN_BBOX_EN for both bench and RTL to exercise the bbox feature.
module tb_iter_span_builder;

    localparam int E = 1023;  // x0 of an empty span

`ifdef ITER_SPAN_BBOX_EN
    localparam int LAT_SQ  = 11 + 168 + 1;
    localparam int RST_AT  = 41 + 10;
    localparam int LAT_478 = 10 + 23 + 1;
    localparam int LAT_ONE = 2 + 2 + 1;
`else
    localparam int LAT_SQ  = 480 + 168 + 1;
    localparam int RST_AT  = 480 + 10;
    localparam int LAT_478 = 480 + 23 + 1;
    localparam int LAT_ONE = 480 + 2 + 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vert_we = 1'b0;
    logic [1:0] vert_idx = '0;
    logic [9:0] vert_x = '0, vert_y = '0;
    logic [2:0] nvert = '0;
    logic       start = 1'b0;
    logic [9:0] y = '0;
    logic [9:0] x0, x1;
    logic       busy, done;
`ifdef ITER_SPAN_BBOX_EN
    logic [9:0] bbox_y0, bbox_y1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int ph;
        int row;
        int x0;
        int x1;
    } vec_t;

    vec_t vecs [22];

    always #5 clk = ~clk;

    iter_span_builder #(.CORDW(10), .SCREEN_H(480), .MAXV(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .vert_we  (vert_we),
        .vert_idx (vert_idx),
        .vert_x   (vert_x),
        .vert_y   (vert_y),
        .nvert    (nvert),
        .start    (start),
        .y        (y),
        .x0       (x0),
        .x1       (x1),
        .busy     (busy),
        .done     (done)
`ifdef ITER_SPAN_BBOX_EN
        ,
        .bbox_y0  (bbox_y0),
        .bbox_y1  (bbox_y1)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic put_vert(input int idx, input int px, input int py);
        @(negedge clk);
        vert_we  = 1'b1;
        vert_idx = 2'(idx);
        vert_x   = 10'(px);
        vert_y   = 10'(py);
        @(negedge clk);
        vert_we  = 1'b0;
    endtask

    task automatic run_phase(input int ph);
        foreach (vecs[i]) begin
            if (vecs[i].ph == ph) begin
                y = 10'(vecs[i].row);
                #1;
                check($sformatf("ph%0d row%0d x0", ph, vecs[i].row), 32'(x0), 32'(vecs[i].x0));
                check($sformatf("ph%0d row%0d x1", ph, vecs[i].row), 32'(x1), 32'(vecs[i].x1));
            end
        end
    endtask

    // Starts a build and waits (bounded) for done. we_with_start raises vert_we
    // in the start cycle using the preloaded vert_idx/x/y; mid_at >= 0 pulses
    // start plus a vertex write at that cycle of the build.
    task automatic build(input int nv, input int lat_exp, input int probe,
                         input int mid_at, input bit we_with_start, input string name);
        int cnt;
        int bad;
        y     = 10'(probe);
        nvert = 3'(nv);
        @(negedge clk);
        start   = 1'b1;
        vert_we = we_with_start;
        @(negedge clk);
        start   = 1'b0;
        vert_we = 1'b0;
        cnt = 0;
        bad = 0;
        while (!done && cnt < 3000) begin
            if (!busy || x0 !== 10'h3ff || x1 !== 10'h000) bad++;
            if (cnt == mid_at) begin
                start    = 1'b1;
                vert_we  = 1'b1;
                vert_idx = 2'd0;
                vert_x   = 10'd300;
                vert_y   = 10'd300;
            end else begin
                start   = 1'b0;
                vert_we = 1'b0;
            end
            @(negedge clk);
            cnt++;
        end
        start   = 1'b0;
        vert_we = 1'b0;
        check({name, " latency"}, 32'(cnt), 32'(lat_exp));
        check({name, " busy reads"}, 32'(bad), 32'd0);
        check({name, " busy at done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({name, " done one cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        int sum;

        vecs = '{
            '{0,   0, E,   0}, '{0,  10, E,   0},
            '{1,  10, 10,  20}, '{1,  15, 10,  15}, '{1,  20, 10,  10},
            '{1,   9, E,   0}, '{1,  21, E,   0},
            '{2,  50, 100, 140}, '{2,  70, 100, 140}, '{2,  90, 100, 140},
            '{2,  91, E,   0}, '{2,  49, E,   0}, '{2,  15, E,   0},
            '{3,  10, E,   0},
            '{4, 479, 0,   5}, '{4, 470, 0,   0},
            '{5, 478, 0,   3}, '{5, 479, 0,   3}, '{5, 470, E,   0}, '{5, 480, E, 0},
            '{6, 478, 0,   0}, '{6, 479, E,   0}
        };

        // Reset state and reads before any build
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        run_phase(0);

        // Triangle, full clear
        put_vert(0, 10, 10);
        put_vert(1, 20, 10);
        put_vert(2, 10, 20);
        build(3, 517, 10, -1, 1'b0, "tri");
        run_phase(1);
`ifdef ITER_SPAN_BBOX_EN
        check("tri bbox_y0", 32'(bbox_y0), 32'd10);
        check("tri bbox_y1", 32'(bbox_y1), 32'd20);
`endif

        // Square with nvert clamped from 7, start and vert_we pulsed at cycle 5
        put_vert(0, 100, 50);
        put_vert(1, 140, 50);
        put_vert(2, 140, 90);
        put_vert(3, 100, 90);
        build(7, LAT_SQ, 15, 5, 1'b0, "sq");
        run_phase(2);
        sum = 0;
        for (int r = 0; r < 480; r++) begin
            y = 10'(r);
            #1;
            if (x0 <= x1) sum += int'(x1) - int'(x0) + 1;
        end
        check("sq pixel count", 32'(sum), 32'd1681);
`ifdef ITER_SPAN_BBOX_EN
        check("sq bbox_y0", 32'(bbox_y0), 32'd50);
        check("sq bbox_y1", 32'(bbox_y1), 32'd90);
`endif

        // Reset pulse in the middle of EDGE_WALK
        nvert = 3'd4;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (RST_AT) @(negedge clk);
        check("pre-reset busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_phase(3);

        // Bottom-edge polygon; last vertex written in the start cycle
        put_vert(0, 0, 479);
        put_vert(1, 5, 479);
        vert_idx = 2'd2;
        vert_x   = 10'd0;
        vert_y   = 10'd470;
        build(3, 510, 479, -1, 1'b1, "bot");
        run_phase(4);
`ifdef ITER_SPAN_BBOX_EN
        check("bot bbox_y0", 32'(bbox_y0), 32'd470);
        check("bot bbox_y1", 32'(bbox_y1), 32'd479);
`endif

        // Polygon extending past the last row: off-screen points still cost cycles
        put_vert(0, 0, 478);
        put_vert(1, 3, 478);
        put_vert(2, 0, 485);
        build(3, LAT_478, 0, -1, 1'b0, "off");
        run_phase(5);

        // Single vertex: one-pixel edge v0 -> v0
        build(1, LAT_ONE, 0, -1, 1'b0, "one");
        run_phase(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iter_span_builder.md
Name: iter_span_builder

Overview:
- Upstream neighbour of the per-row line scanner. Rasterises the outline of one convex polygon (up to MAXV vertices; Tangram pieces are 3 or 4) into a per-row span table by walking each edge with Bresenham.
- The scanner presents y and reads back [x0, x1] combinationally.
- Rows the polygon does not touch read as empty (x0 > x1), so the scanner skips them.

Parameters:
- CORDW, 10, coordinate width in bits.
- SCREEN_H, 480, number of table rows (valid y is 0..SCREEN_H-1).
- MAXV, 4, maximum vertex count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- vert_we  in  1  write one vertex register.
- vert_idx  in  $clog2(MAXV)  vertex index written.
- vert_x  in  CORDW  vertex x.
- vert_y  in  CORDW  vertex y.
- nvert  in  $clog2(MAXV)+1  vertex count used by the next build, sampled at start.
- start  in  1  begin a build; ignored while busy.
- y  in  CORDW  read row (driven by the scanner).
- x0  out  CORDW  span left for row y.
- x1  out  CORDW  span right for row y.
- busy  out  1  build in progress.
- done  out  1  one-cycle pulse at build completion.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, busy=0, done=0, valid=0.
  - Vertex registers and table contents are not cleared.
- Read port:
  - x0/x1 is a combinational (asynchronous-read) lookup of the table at y.
  - When busy=1, valid=0, or y>=SCREEN_H, the outputs are forced to the empty span: x0=all ones, x1=0.
  - valid sets on the first done and clears only on reset.
- Vertex writes: accepted only in IDLE; vert_we while busy is ignored.
- States:
  - IDLE: done=0. On start: latch nvert, busy=1, row counter=0, go to CLEAR.
  - CLEAR: one row per cycle, writing x0=all ones, x1=0, for rows 0..SCREEN_H-1 (SCREEN_H cycles). Then edge index=0. If nvert==0 go to FINISH, else go to EDGE_INIT.
  - EDGE_INIT (1 cycle):
    - Edge endpoints are v[i] and v[(i+1) mod nvert].
    - Load dx=|xb-xa|, dy=-|yb-ya|, sx/sy = ±1, err=dx+dy, current point = (xa, ya).
    - Signed arithmetic width is CORDW+2.
  - EDGE_WALK (1 pixel per cycle):
    - Read-modify-write row cy: x0=min(x0,cx), x1=max(x1,cx).
    - Points with cy>=SCREEN_H are not written but still consume their cycle.
    - Step using the standard Bresenham error update.
    - On the cycle that writes the endpoint: i++, and go to EDGE_INIT if i<nvert, else FINISH.
    - Each edge costs max(|dx|,|dy|)+2 cycles.
- FINISH: busy=0, done=1 for exactly one cycle, valid=1, go to IDLE.
- Latency: from the start-accept edge to done high = SCREEN_H + Σ(max(|dx|,|dy|)+2) + 1 cycles.
- Boundary cases:
  - nvert=1: a single-pixel edge v0→v0.
  - nvert>MAXV: clamped to MAXV.
  - Horizontal edges write one row repeatedly (min/max accumulate).
  - Shared vertices are written twice, which is harmless.
  - start in the same cycle as vert_we: the write lands first, and the build uses the new vertex.
  - start while busy: ignored, no effect.
  - Reset mid-build: immediate return to IDLE. The table is left partial but reads as empty because valid=0.

Optional Feature:
- Macro: ITER_SPAN_BBOX_EN.
- Defined:
  - Adds outputs bbox_y0 and bbox_y1 (CORDW each), giving the min and max written row, updated during EDGE_WALK and stable from done onward.
  - CLEAR then covers only the previous build's bbox rows (all rows on the first build after reset).
  - The latency formula replaces SCREEN_H with that row count.
- Undefined: no bbox ports, and CLEAR always covers SCREEN_H rows.

Test Plan:
- Triangle (10,10),(20,10),(10,20), nvert=3, start → done exactly 517 cycles after start accepted (480 + 36 + 1). Then y=10 → (10,20); y=15 → (10,15); y=20 → (10,10); y=9 and y=21 → x0=1023, x1=0.
- Square (100,50),(140,50),(140,90),(100,90), nvert=4 → rows 50..90 read (100,140); row 91 empty. Back-to-back scanner run draws 41×41 pixels.
- Reads during busy → x0=1023, x1=0 every cycle. After reset, before the first build: y=0 → empty.
- start asserted at cycle 5 of a build → ignored; exactly one done pulse; busy stays 1 until FINISH.
- rst_n low for 1 cycle mid-EDGE_WALK → busy=0 and done=0 immediately (asynchronous). A subsequent full build with (0,479),(5,479),(0,470) gives row 479 = (0,5), and row 480-range points are not written.
- With ITER_SPAN_BBOX_EN: build the triangle above → bbox_y0=10, bbox_y1=20. A second build of a square at rows 50..90 has latency 11 + 168 + 1 = 180 cycles.
